// File: rtl/board_pkg.sv
// Shared definitions for the board MMIO subsystem: region codes, GPIO register
// offsets and the request/response FSM state type.
package board_pkg;

    localparam logic [3:0] REGION_RAM    = 4'h1;
    localparam logic [3:0] REGION_GPIO   = 4'h2;

    localparam logic [3:0] GPIO_LED      = 4'h0;
    localparam logic [3:0] GPIO_SW       = 4'h4;
    localparam logic [3:0] GPIO_CYCLE_LO = 4'h8;
    localparam logic [3:0] GPIO_CYCLE_HI = 4'hC;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // Word accesses only: any set byte-offset bit is a fault.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return (byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/board_mmio_switch_conditioner.sv
// One switch input: 2-flop synchronizer, optionally followed by a debounce
// counter when BOARD_MMIO_DEBOUNCE_EN is defined.
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sw,
    output logic o_sw
);

    logic r_sync1;
    logic r_sync2;

    // Bring the asynchronous switch level into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef BOARD_MMIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_stable;

    // Accept a new level only after it has differed from the current one for
    // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 != r_stable) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt    <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_sw = r_stable;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign o_sw = r_sync2;
`endif

endmodule

// File: rtl/board_mmio.sv
// Memory-mapped board target: word RAM, LED register, synchronised switches and
// a 64-bit cycle counter behind a single valid/ready request/response port.
// Optional switch debouncing is enabled by defining BOARD_MMIO_DEBOUNCE_EN.
module board_mmio
    import board_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int NUM_SW          = 4,
    parameter int NUM_LED         = 4,
    parameter int RAM_WORDS       = 1024,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [XLEN-1:0]    req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    input  logic [3:0]         req_wstrb,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [XLEN-1:0]    rsp_rdata,
    output logic               rsp_err,
    input  logic [NUM_SW-1:0]  switch,
    output logic [NUM_LED-1:0] led
);

    localparam int AW = $clog2(RAM_WORDS);

    state_t              r_state;
    logic                r_rsp_valid;
    logic [XLEN-1:0]     r_rdata;
    logic                r_err;
    logic                r_sel_ram;
    logic [XLEN-1:0]     r_ram_q;
    logic [NUM_LED-1:0]  r_led;
    logic [63:0]         r_cycle;
    logic [XLEN-1:0]     r_mem [RAM_WORDS];

    logic                w_accept;
    logic [AW-1:0]       w_idx;
    logic [NUM_SW-1:0]   w_sw;
    logic [XLEN-1:0]     w_led_ext;
    logic [XLEN-1:0]     w_sw_ext;
    logic                w_err;
    logic [XLEN-1:0]     w_rdata;
    logic                w_ram_rd;
    logic                w_ram_we;
    logic                w_led_we;
    logic                w_unused;

    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign w_idx     = req_addr[2 +: AW];
    // Address bits above the RAM index are deliberately ignored (aliasing).
    assign w_unused  = ^req_addr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
            switch_conditioner #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_cond (
                .clk   (clk),
                .reset (reset),
                .i_sw  (switch[gi]),
                .o_sw  (w_sw[gi])
            );
        end
    endgenerate

    // Zero-extend the narrow GPIO registers to bus width.
    always_comb begin
        w_led_ext = '0;
        w_sw_ext  = '0;
        w_led_ext[NUM_LED-1:0] = r_led;
        w_sw_ext[NUM_SW-1:0]   = w_sw;
    end

    // Address decode: read data for register reads, fault flag, write enables.
    always_comb begin
        w_err    = 1'b0;
        w_rdata  = '0;
        w_ram_rd = 1'b0;
        w_ram_we = 1'b0;
        w_led_we = 1'b0;
        if (is_misaligned(req_addr[1:0])) begin
            w_err = 1'b1;
        end else begin
            case (req_addr[31:28])
                REGION_RAM: begin
                    if (req_we) w_ram_we = 1'b1;
                    else        w_ram_rd = 1'b1;
                end
                REGION_GPIO: begin
                    case (req_addr[3:0])
                        GPIO_LED: begin
                            if (req_we) w_led_we = req_wstrb[0];
                            else        w_rdata  = w_led_ext;
                        end
                        GPIO_SW: begin
                            if (req_we) w_err   = 1'b1;
                            else        w_rdata = w_sw_ext;
                        end
                        GPIO_CYCLE_LO: begin
                            if (req_we) w_err   = 1'b1;
                            else        w_rdata = r_cycle[31:0];
                        end
                        GPIO_CYCLE_HI: begin
                            if (req_we) w_err   = 1'b1;
                            else        w_rdata = r_cycle[63:32];
                        end
                        default: w_err = 1'b1;
                    endcase
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    // Request/response FSM with registered response fields held until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_sel_ram   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= w_rdata;
                        r_err       <= w_err;
                        r_sel_ram   <= w_ram_rd;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Byte-enabled synchronous RAM; read port only loads on an accepted read so
    // its output stays stable for the whole response.
    always_ff @(posedge clk) begin
        if (w_accept && w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
        if (w_accept && w_ram_rd) begin
            r_ram_q <= r_mem[w_idx];
        end
    end

    // LED register, written through byte lane 0 only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led <= '0;
        end else if (w_accept && w_led_we) begin
            r_led <= req_wdata[NUM_LED-1:0];
        end
    end

    // Free-running cycle counter, wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= 64'd0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_sel_ram ? r_ram_q : r_rdata;
    assign rsp_err   = r_err;
    assign led       = r_led;

endmodule

// File: tb/tb_board_mmio.sv
// Scoreboard bench for board_mmio: directed requests push expected responses,
// a negedge monitor pops and compares each completed response.
module tb_board_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  sw;
    logic [3:0]  led;

    always #5 clk = ~clk;

    board_mmio dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .switch    (sw),
        .led       (led)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        rel;   // rdata is a delta from the previous response
        string       name;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] prev_rdata = 32'd0;
    logic [63:0] tb_cyc = 64'd0;

    // Reference cycle count: zero while in reset, +1 per clock afterwards.
    always @(posedge clk) begin
        if (reset) tb_cyc <= 64'd0;
        else       tb_cyc <= tb_cyc + 64'd1;
    end

    // Response monitor: compare every consumed response with the queue head.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] er;
        if (!reset && rsp_valid && rsp_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
            end else begin
                e  = q.pop_front();
                er = e.rel ? (prev_rdata + e.rdata) : e.rdata;
                if (rsp_rdata !== er || rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL %s: got rdata=%h err=%b, required rdata=%h err=%b",
                             e.name, rsp_rdata, rsp_err, er, e.err);
                end
            end
            prev_rdata = rsp_rdata;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Drive one request and return once it has been accepted; acc_cyc is the
    // reference counter value in the acceptance cycle.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [63:0] acc_cyc);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL req_timeout: got req_ready=0 for 50 cycles, required 1 at addr %h", addr);
        end
        acc_cyc = tb_cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_rdata,
                         input logic exp_err, input string name);
        exp_t        e;
        logic [63:0] c;
        send(we, addr, wdata, strb, c);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.rel   = 1'b0;
        e.name  = name;
        q.push_back(e);
    endtask

    // Cycle counter read; expected value from the reference count, or as a
    // fixed delta from the previous response when rel is set.
    task automatic issue_cyc(input logic hi, input logic rel, input logic [31:0] delta,
                             input string name);
        exp_t        e;
        logic [63:0] c;
        send(1'b0, hi ? 32'h2000_000C : 32'h2000_0008, 32'd0, 4'h0, c);
        e.rdata = rel ? delta : (hi ? c[63:32] : c[31:0]);
        e.err   = 1'b0;
        e.rel   = rel;
        e.name  = name;
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        logic [63:0] c;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_wstrb = 4'h0;
        rsp_ready = 1'b1;
        sw        = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        check("rst_led",       {28'd0, led}, 32'd0);
        reset = 1'b0;

        // RAM: full write, byte write, alias, zero-strobe write
        issue(1'b1, 32'h1000_0010, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, "ram_wr");
        issue(1'b0, 32'h1000_0010, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, "ram_rd");
        issue(1'b1, 32'h1000_0010, 32'h0000_00AA, 4'b0001, 32'd0, 1'b0, "ram_wr_b0");
        issue(1'b0, 32'h1000_0010, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0, "ram_rd_b0");
        issue(1'b0, 32'h1000_1010, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0, "ram_alias");
        issue(1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 4'h0, 32'd0, 1'b0, "ram_wr_s0");
        issue(1'b0, 32'h1000_0010, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0, "ram_rd_s0");
        issue(1'b1, 32'h1000_0024, 32'h1234_5678, 4'b1100, 32'd0, 1'b0, "ram_wr_hi");
        issue(1'b0, 32'h1000_0010, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0, "ram_rd_other");

        // LED: visible in the cycle after acceptance
        issue(1'b1, 32'h2000_0000, 32'h0000_0005, 4'hF, 32'd0, 1'b0, "led_wr");
        check("led_t1", {28'd0, led}, 32'h0000_0005);
        issue(1'b0, 32'h2000_0000, 32'd0, 4'h0, 32'h0000_0005, 1'b0, "led_rd");
        issue(1'b1, 32'h2000_0000, 32'h0000_000F, 4'b1110, 32'd0, 1'b0, "led_wr_nob0");
        issue(1'b0, 32'h2000_0000, 32'd0, 4'h0, 32'h0000_0005, 1'b0, "led_rd_nob0");

        // Switches through the synchronizer (and debounce, if built in)
        @(negedge clk);
        sw = 4'b1010;
`ifdef BOARD_MMIO_DEBOUNCE_EN
        repeat (22) @(negedge clk);
`else
        repeat (3) @(negedge clk);
`endif
        issue(1'b0, 32'h2000_0004, 32'd0, 4'h0, 32'h0000_000A, 1'b0, "sw_rd");
`ifdef BOARD_MMIO_DEBOUNCE_EN
        @(negedge clk);
        sw = 4'b0101;
        repeat (3) @(negedge clk);
        sw = 4'b1010;
        repeat (25) @(negedge clk);
        issue(1'b0, 32'h2000_0004, 32'd0, 4'h0, 32'h0000_000A, 1'b0, "sw_glitch");
`endif

        // Faults
        issue(1'b0, 32'h1000_0002, 32'd0, 4'h0, 32'd0, 1'b1, "err_misaligned");
        issue(1'b0, 32'h3000_0000, 32'd0, 4'h0, 32'd0, 1'b1, "err_unmapped");
        issue(1'b0, 32'h0000_0010, 32'd0, 4'h0, 32'd0, 1'b1, "err_region0");
        issue(1'b1, 32'h2000_0004, 32'h0000_0005, 4'hF, 32'd0, 1'b1, "err_wr_sw");
        issue(1'b0, 32'h2000_0004, 32'd0, 4'h0, 32'h0000_000A, 1'b0, "sw_after_wr");
        issue(1'b1, 32'h2000_0008, 32'h0000_0000, 4'hF, 32'd0, 1'b1, "err_wr_cyc");
        issue(1'b1, 32'h2000_0001, 32'h0000_000F, 4'hF, 32'd0, 1'b1, "err_led_mis");
        issue(1'b0, 32'h2000_0000, 32'd0, 4'h0, 32'h0000_0005, 1'b0, "led_after_err");

        // Cycle counter: absolute values, then back-to-back LO reads 2 apart
        issue_cyc(1'b1, 1'b0, 32'd0, "cyc_hi");
        issue_cyc(1'b0, 1'b0, 32'd0, "cyc_lo_a");
        issue_cyc(1'b0, 1'b1, 32'd2, "cyc_lo_delta");
        drain();

        // Backpressure: response held stable, no new request taken
        rsp_ready = 1'b0;
        issue(1'b0, 32'h2000_0000, 32'd0, 4'h0, 32'h0000_0005, 1'b0, "stall_rsp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_rdata", rsp_rdata, 32'h0000_0005);
            check("stall_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        drain();

        // Reset while a response is pending drops it
        rsp_ready = 1'b0;
        send(1'b0, 32'h2000_0000, 32'd0, 4'h0, c);
        @(negedge clk);
        check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_led",   {28'd0, led}, 32'd0);
        check("midrst_ready", {31'd0, req_ready}, 32'd0);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        issue(1'b0, 32'h1000_0010, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0, "ram_kept");
        issue(1'b0, 32'h2000_0000, 32'd0, 4'h0, 32'h0000_0000, 1'b0, "led_rd_rst");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
